// File: rtl/regfile_loader.sv
// Byte-serial preloader for the 32x32 register file write port.
// Optional trailing-checksum check is enabled by defining REGFILE_LOADER_CHECKSUM_EN.
module regfile_loader #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  first_idx,
  input  logic [5:0]  count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef REGFILE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
  localparam state_t S_TAIL = S_CHECK;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t      state, state_nxt;
  logic [1:0]  bcnt;
  logic [23:0] word_lo;
  logic [4:0]  idx;
  logic [5:0]  rem;

  logic        start_ok;
  logic        accept;
  logic        last_byte;
  logic [5:0]  count_sat;
  logic [31:0] full_word;

  assign start_ok  = (state == S_IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (bcnt == 2'd3);
  assign full_word = {in_data, word_lo};
  assign count_sat = (count > 6'd32) ? 6'd32 : count;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; S_TAIL is CHECK when the checksum word is expected, else DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (count_sat != 6'd0) ? S_COLLECT : S_TAIL;
      S_COLLECT: if (last_byte) state_nxt = S_WRITE;
      S_WRITE:   state_nxt = (rem == 6'd1) ? S_TAIL : S_COLLECT;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      S_CHECK:   if (last_byte) state_nxt = S_DONE;
`endif
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_COLLECT: in_ready = 1'b1;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      S_CHECK:   in_ready = 1'b1;
`endif
      S_WRITE:   we = !(SKIP_ZERO && (idx == 5'd0));
      default:   ;
    endcase
  end

  // Byte assembly, index/remaining bookkeeping and write-port registers.
  // waddr/wdata are loaded as the word completes so they are valid during
  // WRITE and hold afterwards, including for suppressed r0 writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt    <= 2'd0;
      word_lo <= 24'd0;
      idx     <= 5'd0;
      rem     <= 6'd0;
      waddr   <= 5'd0;
      wdata   <= 32'd0;
    end else begin
      if (start_ok) begin
        idx  <= first_idx;
        rem  <= count_sat;
        bcnt <= 2'd0;
      end
      if (accept) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    word_lo[7:0]   <= in_data;
          2'd1:    word_lo[15:8]  <= in_data;
          2'd2:    word_lo[23:16] <= in_data;
          default: ;
        endcase
      end
      if (last_byte && (state == S_COLLECT)) begin
        waddr <= idx;
        wdata <= full_word;
      end
      if (state == S_WRITE) begin
        idx <= idx + 5'd1;
        rem <= rem - 6'd1;
      end
    end
  end

`ifdef REGFILE_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        err_q;

  // Running sum covers every data word, including ones whose write is suppressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= 32'd0;
      err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        sum   <= 32'd0;
        err_q <= 1'b0;
      end
      if (last_byte && (state == S_COLLECT)) sum <= sum + full_word;
      if (last_byte && (state == S_CHECK))   err_q <= (full_word != sum);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
